// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: sizes, sequencer FSM encoding, S-box, rcon and
// the fixed round transforms used by the round datapath and key schedule.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_fsm_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] AES_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return AES_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] aes_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the state sits at bits [127-8k -: 8] (column-major, byte 0 first).
    function automatic logic [127:0] aes_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'd0;
        for (int k = 0; k < 16; k++) begin
            o[8*(15-k) +: 8] = aes_sbox(s[8*(15-k) +: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c+r)%4)+r)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(15-4*c)   +: 8];
            a1 = s[8*(14-4*c)   +: 8];
            a2 = s[8*(13-4*c)   +: 8];
            a3 = s[8*(12-4*c)   +: 8];
            o[8*(15-4*c) +: 8] = aes_xtime(a0) ^ aes_xtime(a1) ^ a1 ^ a2 ^ a3;
            o[8*(14-4*c) +: 8] = a0 ^ aes_xtime(a1) ^ aes_xtime(a2) ^ a2 ^ a3;
            o[8*(13-4*c) +: 8] = a0 ^ a1 ^ aes_xtime(a2) ^ aes_xtime(a3) ^ a3;
            o[8*(12-4*c) +: 8] = aes_xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes128_key_step.sv
// Combinational AES-128 key schedule step: derives the next round key from the
// current one and the round constant.
module aes128_key_step
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] rkey,
    input  logic [7:0]           rcon,
    output logic [AES_BLK_W-1:0] rkey_next
);

    logic [31:0] w0_s, w1_s, w2_s, w3_s;
    logic [31:0] rot_s, temp_s;
    logic [31:0] n0_s, n1_s, n2_s, n3_s;

    // RotWord, SubWord and rcon on the last word, then the chained word XOR.
    always_comb begin
        w0_s   = rkey[127:96];
        w1_s   = rkey[95:64];
        w2_s   = rkey[63:32];
        w3_s   = rkey[31:0];
        rot_s  = {w3_s[23:0], w3_s[31:24]};
        temp_s = {aes_sbox(rot_s[31:24]), aes_sbox(rot_s[23:16]),
                  aes_sbox(rot_s[15:8]),  aes_sbox(rot_s[7:0])} ^ {rcon, 24'h000000};
        n0_s   = w0_s ^ temp_s;
        n1_s   = w1_s ^ n0_s;
        n2_s   = w2_s ^ n1_s;
        n3_s   = w3_s ^ n2_s;
        rkey_next = {n0_s, n1_s, n2_s, n3_s};
    end

endmodule

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key schedule,
// valid/ready handshake on plaintext input and ciphertext output.
module aes128_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR      = AES_NR,
    parameter int ROUND_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_text,
    input  logic [AES_BLK_W-1:0] in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_text,
    output logic                 busy,
    output logic [ROUND_W-1:0]   round
);

    if (NR != AES_NR) begin : g_bad_nr
        $error("aes128_round_sequencer: NR must be 10 for AES-128");
    end
    if ((1 << ROUND_W) <= NR) begin : g_bad_round_w
        $error("aes128_round_sequencer: ROUND_W too narrow to hold NR");
    end

    aes_fsm_e               fsm_q, fsm_d;
    logic [AES_BLK_W-1:0]   state_q, state_d;
    logic [AES_BLK_W-1:0]   rkey_q, rkey_d;
    logic [ROUND_W-1:0]     round_q, round_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;

    logic [AES_BLK_W-1:0]   rk_next_s;
    logic [AES_BLK_W-1:0]   sr_s;
    logic [AES_BLK_W-1:0]   round_out_s;
    logic                   last_round_s;

    aes128_key_step u_key_step (
        .rkey      (rkey_q),
        .rcon      (aes_rcon(4'(round_q))),
        .rkey_next (rk_next_s)
    );

    // Round datapath; the final round skips MixColumns.
    always_comb begin
        last_round_s = (round_q >= ROUND_W'(NR));
        sr_s         = aes_shift_rows(aes_sub_bytes(state_q));
        if (last_round_s) begin
            round_out_s = sr_s ^ rk_next_s;
        end else begin
            round_out_s = aes_mix_columns(sr_s) ^ rk_next_s;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rkey_d      = rkey_q;
        round_d     = round_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = in_text ^ in_key;
                    rkey_d     = in_key;
                    round_d    = ROUND_W'(1);
                    fsm_d      = ROUND;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            ROUND: begin
                state_d    = round_out_s;
                rkey_d     = rk_next_s;
                in_ready_d = 1'b0;
                busy_d     = 1'b1;
                if (last_round_s) begin
                    fsm_d       = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    round_d = round_q + ROUND_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d       = IDLE;
                    out_valid_d = 1'b0;
                    round_d     = '0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    in_ready_d  = 1'b0;
                end
            end
            default: begin
                fsm_d       = IDLE;
                round_d     = '0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State registers; reset aborts any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            rkey_q      <= '0;
            round_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rkey_q      <= rkey_d;
            round_q     <= round_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_text  = state_q;
    assign busy      = busy_q;
    assign round     = round_q;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Self-checking bench: FIPS-197 vectors, handshake corner cases and random
// blocks compared against an array-based AES-128 reference model.
module tb_aes128_round_sequencer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_text;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;
    logic         busy;
    logic [3:0]   round;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    logic [7:0] sbt [256];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_round_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_text   (in_text),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_text  (out_text),
        .busy      (busy),
        .round     (round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 16; k++) st[k] = pt[127-8*k -: 8] ^ key[127-8*k -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) st[k] = sbt[st[k]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) tmp[4*c+row] = st[4*((c+row)%4)+row];
            for (int c = 0; c < 4; c++) begin
                for (int row = 0; row < 4; row++) begin
                    if (r < 10)
                        st[4*c+row] = gmul(tmp[4*c+row], 8'h02) ^ gmul(tmp[4*c+(row+1)%4], 8'h03)
                                    ^ tmp[4*c+(row+2)%4] ^ tmp[4*c+(row+3)%4];
                    else
                        st[4*c+row] = tmp[4*c+row];
                end
                for (int row = 0; row < 4; row++) st[4*c+row] = st[4*c+row] ^ w[4*r+c][31-8*row -: 8];
            end
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = st[k];
        return res;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Offer a block and return just after the accepting edge.
    task automatic start(input logic [127:0] pt, input logic [127:0] key);
        in_text  = pt;
        in_key   = key;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) cyc();
        check_value("in_ready_before_accept", 128'(in_ready), 128'd1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            cyc();
            lat++;
        end
        check_value(tag, 128'(lat), 128'd10);
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check_value("in_ready_after_out", 128'(in_ready), 128'd1);
        check_value("out_valid_dropped", 128'(out_valid), 128'd0);
    endtask

    initial begin : main
        logic [127:0] hold_text, pt, key, exp_q[$];
        int           acc_t[2];
        int           n_acc, n_out, pulse;
        logic         acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_text = 128'd0; in_key = 128'd0;
        build_sbox();
        #1;
        check_value("rst_out_valid", 128'(out_valid), 128'd0);
        check_value("rst_busy", 128'(busy), 128'd0);
        check_value("rst_round", 128'(round), 128'd0);
        check_value("rst_out_text", out_text, 128'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check_value("in_ready_after_rst", 128'(in_ready), 128'd1);

        // App. B with exact latency and round sequence.
        start(PT_B, KEY_B);
        check_value("round_1", 128'(round), 128'd1);
        check_value("busy_round", 128'(busy), 128'd1);
        for (int j = 2; j <= 10; j++) begin
            cyc();
            check_value($sformatf("round_%0d", j), 128'(round), 128'(j));
            check_value("out_valid_early", 128'(out_valid), 128'd0);
        end
        cyc();
        check_value("out_valid_t10", 128'(out_valid), 128'd1);
        check_value("ct_appB", out_text, CT_B);
        finish_out();

        // App. C.1 and all-zero vectors.
        start(PT_C, KEY_C);
        wait_out("lat_appC");
        check_value("ct_appC", out_text, CT_C);
        finish_out();
        start(128'd0, 128'd0);
        wait_out("lat_zero");
        check_value("ct_zero", out_text, CT_Z);
        finish_out();

        // Backpressure with in_valid pulses that must not be taken.
        start(PT_B, KEY_B);
        wait_out("lat_bp");
        hold_text = out_text;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_text  = {$urandom, $urandom, $urandom, $urandom};
            cyc();
            check_value("bp_out_valid", 128'(out_valid), 128'd1);
            check_value("bp_out_text", out_text, hold_text);
            check_value("bp_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        check_value("ct_bp", hold_text, CT_B);
        finish_out();

        // Input corruption while busy.
        start(PT_B, KEY_B);
        for (int i = 0; i < 40 && !out_valid; i++) begin
            in_text  = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            in_valid = ~in_valid;
            cyc();
        end
        in_valid = 1'b0;
        check_value("ct_corrupt", out_text, CT_B);
        finish_out();

        // Back-to-back with out_ready tied high.
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        exp_q = {CT_C, aes_ref(pt, key)};
        out_ready = 1'b1;
        in_text = PT_C; in_key = KEY_C; in_valid = 1'b1;
        n_acc = 0; n_out = 0;
        for (int i = 0; i < 60 && n_out < 2; i++) begin
            if (out_valid) begin
                check_value($sformatf("b2b_ct_%0d", n_out), out_text, exp_q[n_out]);
                n_out++;
            end
            acc = in_valid && in_ready;
            cyc();
            if (acc) begin
                acc_t[n_acc] = cyc_n;
                n_acc++;
                if (n_acc < 2) begin
                    in_text = pt; in_key = key;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        check_value("b2b_outputs", 128'(n_out), 128'd2);
        check_value("b2b_accepts", 128'(n_acc), 128'd2);
        check_value("b2b_interval", 128'(acc_t[1] - acc_t[0]), 128'd12);
        cyc();

        // Random blocks against the reference model.
        for (int n = 0; n < 6; n++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            start(pt, key);
            wait_out("lat_rand");
            repeat ($urandom_range(0, 3)) cyc();
            check_value($sformatf("ct_rand_%0d", n), out_text, aes_ref(pt, key));
            finish_out();
        end

        // Reset in the middle of round 5.
        start(PT_B, KEY_B);
        for (int i = 0; i < 20 && round != 4'd5; i++) cyc();
        check_value("reached_round5", 128'(round), 128'd5);
        rst_n = 1'b0;
        #1;
        check_value("midrst_out_valid", 128'(out_valid), 128'd0);
        check_value("midrst_busy", 128'(busy), 128'd0);
        check_value("midrst_round", 128'(round), 128'd0);
        check_value("midrst_out_text", out_text, 128'd0);
        pulse = 0;
        repeat (3) begin
            cyc();
            if (out_valid) pulse = 1;
        end
        rst_n = 1'b1;
        repeat (15) begin
            cyc();
            if (out_valid) pulse = 1;
        end
        check_value("midrst_no_pulse", 128'(pulse), 128'd0);
        start(PT_B, KEY_B);
        wait_out("lat_after_rst");
        check_value("ct_after_rst", out_text, CT_B);
        finish_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes128_round_sequencer.md
Name: aes128_round_sequencer

Overview:
Iterative AES-128 encryption engine controller. It sequences the existing combinational round datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey) over 10 rounds, one round per clock, and generates round keys on the fly. The block wraps the round datapath with a valid/ready handshake on both sides so it can sit between a plaintext source and a ciphertext sink.

Parameters:
NR, 10, number of cipher rounds; only 10 (AES-128) is legal; elaboration error otherwise
ROUND_W, 4, width of the round counter; must hold NR

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  plaintext/key offered
in_ready  out  1  block can accept; high only in IDLE
in_text  in  128  plaintext, [0:127]; byte k = bits [8k:8k+7], column-major state (bytes 0-3 = column 0)
in_key  in  128  cipher key, same bit/byte ordering
out_valid  out  1  ciphertext available
out_ready  in  1  sink accepts ciphertext
out_text  out  128  ciphertext, same ordering
busy  out  1  high in ROUND or DONE
round  out  ROUND_W  current round index, for debug

Behaviour:
- Reset, asynchronous on rst_n low: FSM = IDLE, state_q = 0, rkey_q = 0, round = 0, out_valid = 0, busy = 0, out_text = 0. in_ready = 1 once rst_n is released.
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready = 1. On in_valid: state_q <= in_text XOR in_key (round-0 AddRoundKey), rkey_q <= in_key, round <= 1, go to ROUND.
- ROUND, one cycle per round:
  - rk_next = key_step(rkey_q, rcon[round]).
  - For round < NR: state_q <= MixColumns(ShiftRows(SubBytes(state_q))) XOR rk_next.
  - For round == NR: MixColumns is bypassed.
  - rkey_q <= rk_next.
  - If round == NR, go to DONE; otherwise round <= round + 1.
- DONE: out_valid = 1, out_text = state_q, stable while out_ready is low (no timeout). On out_ready: out_valid <= 0, round <= 0, go to IDLE.
- Latency: handshake accepted at edge T gives out_valid high after edge T+NR (10 ROUND cycles). Minimum issue interval is 12 cycles, because in_ready is low in DONE and returns the cycle after the output handshake.
- Inputs are captured only on an accepted handshake. in_text and in_key changes while busy have no effect. in_valid while busy is ignored and not queued.
- round never exceeds NR. Illegal FSM encodings recover to IDLE.
- rcon table: 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
- Reset asserted mid-operation aborts immediately. The in-flight result is discarded and out_valid never pulses.
- out_text equals state_q in all states. Consumers qualify it with out_valid only.

Decomposition:
- Shared package aes_pkg holds:
  - AES_NR = 10, AES_BLK_W = 128
  - FSM state encoding: IDLE, ROUND, DONE
  - rcon lookup function
  - S-box function reused by SubBytes and the key step
- One sub-module, aes128_key_step: combinational next round key from (rkey, rcon byte) via RotWord, SubWord, rcon XOR, and the word-chain XOR.
- Existing SubBytes, ShiftRows, MixColumns, AddRoundKey blocks are instantiated unchanged for the round datapath.

Test Plan:
1. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_text 3925841d02dc09fbdc118597196a0b32; out_valid rises exactly 10 cycles after the accept edge; round counts 1..10.
2. FIPS-197 App. C.1: key 000102..0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. Zero key and zero pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
3. Backpressure: hold out_ready low for 20 cycles -> out_valid and out_text stay stable. in_valid pulses during this time are not accepted (in_ready = 0). After out_ready, in_ready is high the next cycle.
4. Input corruption while busy: change in_text/in_key and toggle in_valid every cycle during ROUND -> result unchanged from scenario 1.
5. Back-to-back: in_valid held high with two queued vectors and out_ready tied high -> both ciphertexts correct, accepts exactly 12 cycles apart.
6. Reset mid-round: drop rst_n at round 5 -> outputs at reset values immediately, no out_valid pulse. A fresh App. B encryption after release gives the correct result.
